lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter CLEAR_CYCLES, default 38000; busy duration of clear/home commands (1.52 ms at 25 MHz).
REQ-002 Parameter CMD_CYCLES, default 925; busy duration of all other writes (37 us at 25 MHz).
REQ-003 Port clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port lcd_rs, lcd_rw, lcd_e  in  1 each  HD44780 control lines.
REQ-006 Port lcd_data_in  in  8  data from the controller.
REQ-007 Port lcd_data_out  out  8  read data.
REQ-008 Port lcd_data_oe  out  1  high while the responder drives read data.
REQ-009 Port mon_addr  in  7 / mon_data  out  8  combinational DDRAM monitor read port.
REQ-010 Port busy  out  1  mirrors the busy flag.
REQ-011 Port ac  out  7  current address counter.
REQ-012 Port disp_ctrl  out  3  {D,C,B}.
REQ-013 Port busy_violation, cmd_error  out  1 each  single-cycle pulses.

Function
REQ-014 lcd_e, lcd_rs, lcd_rw and lcd_data_in SHALL pass through a 2-flop synchronizer; a transaction SHALL be executed on the cycle a synchronized E falling edge is detected, using the synchronized RS/RW/data sampled in that same cycle.
REQ-015 Write while busy=1 at the edge cycle: ignored, busy_violation pulses; reads SHALL always be accepted.
REQ-016 Read (RW=1) while synchronized E=1: lcd_data_oe=1; RS=0 -> lcd_data_out={busy,ac}; RS=1 -> DDRAM[ac]; RS=1 read SHALL step ac per I/D at the E falling edge.
REQ-017 Commands (RS=0,RW=0) decode by highest set bit.
- 0x01 clear: write 0x20 to all 128 DDRAM entries sequentially (one per cycle); ac=0; I/D=1; busy for CLEAR_CYCLES.
- 0x02/0x03 home: ac=0; busy for CLEAR_CYCLES.
- 0x04-0x07 entry mode: I/D=bit1, S=bit0.
- 0x08-0x0F display: {D,C,B}=bits[2:0].
- 0x10-0x1F shift: S/C=0 steps ac right (bit2=1) or left; S/C=1 has no state effect.
- 0x20-0x3F function set: DL=bit4, N=bit3; DL=0 pulses cmd_error and the old DL/N are kept.
- 0x40-0x7F CGRAM address: cg_mode=1; subsequent data writes/reads are discarded (read returns 0x00) and ac is unchanged.
- 0x80-0xFF DDRAM address: ac=bits[6:0]; cg_mode=0.
REQ-018 Data write (RS=1,RW=0, cg_mode=0): DDRAM[ac]=data; ac steps per I/D.
REQ-019 ac stepping with N=1: 0x27+1->0x40, 0x67+1->0x00, 0x40-1->0x27, 0x00-1->0x67.
REQ-020 ac stepping with N=0: 0x4F+1->0x00, 0x00-1->0x4F.
REQ-021 busy SHALL assert in the cycle after an accepted write and deassert after exactly CMD_CYCLES or CLEAR_CYCLES cycles.
REQ-022 A write edge arriving in the cycle the busy counter reaches zero SHALL be rejected, because busy is evaluated as the registered value.

Reset
REQ-023 On rst_n=0, immediately:
- ac=0, I/D=1, S=0, disp_ctrl=0, DL=1, N=0, cg_mode=0.
- busy=0, busy counter=0.
- lcd_data_oe=0, lcd_data_out=0, pulses=0.
- synchronizers cleared; any in-progress clear aborted.
REQ-024 DDRAM contents SHALL NOT be reset.

Structure
REQ-025 Package lcd_pkg SHALL hold: command-bit positions, entry/display flag typedefs, line-wrap address constants (0x27, 0x40, 0x4F, 0x67), and default timing values.
REQ-026 Sub-module lcd_ddram: 128x8 array, one synchronous write port, two combinational read ports (read path and mon).

Verification
REQ-027 Write 0x38, 0x0C, 0x06, then data 0x48 0x69 -> mon 0x00=0x48, 0x01=0x69; ac=0x02; disp_ctrl=3'b100.
REQ-028 0x80|0x27 then two data writes (N=1) -> entries 0x27 and 0x40 written; ac=0x41.
REQ-029 0x01 -> busy high for 38000 cycles; all 128 entries read 0x20; status read during busy returns 0x80.
REQ-030 Data write at busy cycle 10 after 0x0C -> busy_violation pulse; DDRAM unchanged.
REQ-031 0x04 then 0x80, write 0x41 -> ac=0x67 (N=1); status read returns {busy,0x67}.
REQ-032 Assert rst_n low mid-clear at cycle 50 -> busy=0, ac=0 at once; entries 0..49 are 0x20 and the rest keep prior contents.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command-bit positions, flag types, wrap addresses and timing defaults for the HD44780 responder.
package lcd_pkg;
   localparam int CLEAR_CYCLES_DEF = 38000;
   localparam int CMD_CYCLES_DEF   = 925;
   localparam int B_DDRAM = 7, B_CGRAM = 6, B_FUNC = 5, B_SHIFT = 4;
   localparam int B_DISP  = 3, B_ENTRY = 2, B_HOME = 1, B_CLEAR = 0;
   localparam int B_DL = 4, B_N = 3, B_SC = 3, B_RL = 2;
   localparam logic [6:0] L1_END = 7'h27, L2_START = 7'h40, ONE_LINE_END = 7'h4F, L2_END = 7'h67;
   localparam logic [7:0] BLANK = 8'h20;
   typedef struct packed {logic id; logic s;} entry_t;
   typedef struct packed {logic d; logic c; logic b;} disp_t;
   // Address counter step with HD44780 line wrap for one- and two-line modes.
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic n);
      if (n)
         return inc ? (a == L1_END ? L2_START : a == L2_END ? 7'h00 : a + 7'd1)
                    : (a == L2_START ? L1_END : a == 7'h00 ? L2_END : a - 7'd1);
      return inc ? (a == ONE_LINE_END ? 7'h00 : a + 7'd1) : (a == 7'h00 ? ONE_LINE_END : a - 7'd1);
   endfunction
endpackage

// File: rtl/lcd_responder_if.sv
// lcd_responder_if: HD44780 parallel bus between an LCD controller (master) and the responder (slave).
interface lcd_responder_if;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data_in, lcd_data_out;
   logic       lcd_data_oe;
   modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data_in, input lcd_data_out, lcd_data_oe);
   modport slave (input lcd_rs, lcd_rw, lcd_e, lcd_data_in, output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/lcd_ddram.sv
// lcd_ddram: 128x8 display RAM, one synchronous write port, two combinational read ports; contents are never reset.
module lcd_ddram (
   input  logic       clk,
   input  logic       we_i,
   input  logic [6:0] wa_i,
   input  logic [7:0] wd_i,
   input  logic [6:0] ra_i,
   output logic [7:0] rd_o,
   input  logic [6:0] ma_i,
   output logic [7:0] md_o
);
   logic [7:0] mem_q [128];
   always_ff @(posedge clk)
      if (we_i) mem_q[wa_i] <= wd_i;
   assign rd_o = mem_q[ra_i];
   assign md_o = mem_q[ma_i];
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-compatible LCD controller model answering a host on the parallel bus.
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
   parameter int CMD_CYCLES   = CMD_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   lcd_responder_if.slave  bus,
   input  logic [6:0]      mon_addr,
   output logic [7:0]      mon_data,
   output logic            busy,
   output logic [6:0]      ac,
   output logic [2:0]      disp_ctrl,
   output logic            busy_violation,
   output logic            cmd_error
);
   localparam int CW = $clog2((CLEAR_CYCLES > CMD_CYCLES ? CLEAR_CYCLES : CMD_CYCLES) + 1);
   logic [10:0]   s1_q, s2_q;
   logic          e_prev_q;
   logic [6:0]    ac_q, ac_d, clr_idx_q, clr_idx_d;
   entry_t        em_q, em_d;
   disp_t         disp_q, disp_d;
   logic          dl_q, dl_d, n_q, n_d, cg_q, cg_d, busy_q, busy_d, clr_q, clr_d;
   logic          bv_q, bv_d, ce_q, ce_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          e_s, rs_s, rw_s, fall, wr_edge, acc, oe, we;
   logic [7:0]    d_s, rd_data;
   logic          unused_mode;
   assign {e_s, rs_s, rw_s, d_s} = s2_q;
   assign fall    = e_prev_q & ~e_s;
   assign wr_edge = fall & ~rw_s;
   assign acc     = wr_edge & ~busy_q;
   assign oe      = e_s & rw_s;
   // S and DL are tracked for fidelity but nothing here depends on them.
   assign unused_mode = ^{em_q.s, dl_q};
   always_comb begin
      ac_d      = ac_q;
      em_d      = em_q;
      disp_d    = disp_q;
      dl_d      = dl_q;
      n_d       = n_q;
      cg_d      = cg_q;
      ce_d      = 1'b0;
      bv_d      = wr_edge & busy_q;
      cnt_d     = cnt_q - CW'(cnt_q != '0);
      clr_d     = clr_q & (clr_idx_q != 7'h7F);
      clr_idx_d = clr_idx_q + 7'(clr_q);
      if (fall & rw_s & rs_s & ~cg_q) ac_d = ac_step(ac_q, em_q.id, n_q);
      if (acc) begin
         cnt_d = CW'(CMD_CYCLES);
         if (rs_s) begin
            if (!cg_q) ac_d = ac_step(ac_q, em_q.id, n_q);
         end else if (d_s[B_DDRAM]) begin
            ac_d = d_s[6:0];
            cg_d = 1'b0;
         end else if (d_s[B_CGRAM]) begin
            cg_d = 1'b1;
         end else if (d_s[B_FUNC]) begin
            if (d_s[B_DL]) begin
               dl_d = d_s[B_DL];
               n_d  = d_s[B_N];
            end else ce_d = 1'b1;
         end else if (d_s[B_SHIFT]) begin
            if (!d_s[B_SC]) ac_d = ac_step(ac_q, d_s[B_RL], n_q);
         end else if (d_s[B_DISP]) begin
            disp_d = disp_t'(d_s[2:0]);
         end else if (d_s[B_ENTRY]) begin
            em_d = entry_t'(d_s[1:0]);
         end else if (d_s[B_HOME]) begin
            ac_d  = '0;
            cnt_d = CW'(CLEAR_CYCLES);
         end else if (d_s[B_CLEAR]) begin
            ac_d      = '0;
            em_d.id   = 1'b1;
            cnt_d     = CW'(CLEAR_CYCLES);
            clr_d     = 1'b1;
            clr_idx_d = '0;
         end
      end
      busy_d = cnt_d != '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         e_prev_q  <= 1'b0;
         ac_q      <= '0;
         em_q      <= '{id: 1'b1, s: 1'b0};
         disp_q    <= '0;
         dl_q      <= 1'b1;
         n_q       <= 1'b0;
         cg_q      <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         clr_q     <= 1'b0;
         clr_idx_q <= '0;
         bv_q      <= 1'b0;
         ce_q      <= 1'b0;
      end else begin
         s1_q      <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data_in};
         s2_q      <= s1_q;
         e_prev_q  <= e_s;
         ac_q      <= ac_d;
         em_q      <= em_d;
         disp_q    <= disp_d;
         dl_q      <= dl_d;
         n_q       <= n_d;
         cg_q      <= cg_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         clr_q     <= clr_d;
         clr_idx_q <= clr_idx_d;
         bv_q      <= bv_d;
         ce_q      <= ce_d;
      end
   // The clear sweep owns the write port; host writes cannot overlap it since busy covers the sweep.
   assign we = clr_q | (acc & rs_s & ~cg_q);
   lcd_ddram u_ddram (
      .clk  (clk),
      .we_i (we),
      .wa_i (clr_q ? clr_idx_q : ac_q),
      .wd_i (clr_q ? BLANK : d_s),
      .ra_i (ac_q),
      .rd_o (rd_data),
      .ma_i (mon_addr),
      .md_o (mon_data)
   );
   assign bus.lcd_data_oe  = oe;
   assign bus.lcd_data_out = oe ? (rs_s ? (cg_q ? 8'h00 : rd_data) : {busy_q, ac_q}) : 8'h00;
   assign busy             = busy_q;
   assign ac               = ac_q;
   assign disp_ctrl        = disp_q;
   assign busy_violation   = bv_q;
   assign cmd_error        = ce_q;
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: randomized scoreboard bench for lcd_responder against a display-level reference model.
module tb_lcd_responder;
   localparam int TCLR = 600;
   localparam int TCMD = 40;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] mon_addr = '0;
   logic [7:0] mon_data;
   logic       busy, busy_violation, cmd_error;
   logic [6:0] ac;
   logic [2:0] disp_ctrl;
   int         total = 0, bad = 0;
   lcd_responder_if bus ();
   lcd_responder #(.CLEAR_CYCLES(TCLR), .CMD_CYCLES(TCMD)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .mon_addr(mon_addr), .mon_data(mon_data),
      .busy(busy), .ac(ac), .disp_ctrl(disp_ctrl), .busy_violation(busy_violation), .cmd_error(cmd_error)
   );
   always #5 clk = ~clk;

   logic [7:0] m_mem [128];
   logic [6:0] m_ac = '0;
   logic [2:0] m_disp = '0;
   bit         m_id = 1, m_n = 0, m_cg = 0;
   int         m_dur = 0;
   int         q_busy[$], q_pulse[$];
   logic [7:0] q_rd[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Cursor movement seen as a position on the visible line ring(s).
   function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
      int p;
      if (m_n) begin
         if (a <= 7'h27) p = int'(a);
         else if (a >= 7'h40 && a <= 7'h67) p = int'(a) - 24;
         else return inc ? a + 7'd1 : a - 7'd1;
         p = (p + (inc ? 1 : 79)) % 80;
         return p < 40 ? 7'(p) : 7'(p + 24);
      end
      if (a > 7'h4F) return inc ? a + 7'd1 : a - 7'd1;
      return 7'((int'(a) + (inc ? 1 : 79)) % 80);
   endfunction

   task automatic mdl_write(input bit rs, input logic [7:0] d);
      m_dur = TCMD;
      if (rs) begin
         if (!m_cg) begin
            m_mem[m_ac] = d;
            m_ac = m_step(m_ac, m_id);
         end
      end else if (d >= 128) begin
         m_ac = d[6:0];
         m_cg = 0;
      end else if (d >= 64) m_cg = 1;
      else if (d >= 32) begin
         if (d[4]) m_n = d[3];
         else q_pulse.push_back(2);
      end else if (d >= 16) begin
         if (!d[3]) m_ac = m_step(m_ac, d[2]);
      end else if (d >= 8) m_disp = d[2:0];
      else if (d >= 4) m_id = d[1];
      else if (d >= 2) begin
         m_ac = 0;
         m_dur = TCLR;
      end else if (d == 1) begin
         m_ac = 0;
         m_id = 1;
         m_dur = TCLR;
         for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
      end
      q_busy.push_back(m_dur);
   endtask

   function automatic logic [7:0] mdl_read(input bit rs, input bit bsy);
      logic [7:0] v;
      if (!rs) return {bsy, m_ac};
      if (m_cg) return 8'h00;
      v = m_mem[m_ac];
      m_ac = m_step(m_ac, m_id);
      return v;
   endfunction

   task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
      @(negedge clk);
      bus.lcd_rs = rs;
      bus.lcd_rw = rw;
      bus.lcd_data_in = d;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (6) @(negedge clk);
      bus.lcd_e = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic idle();
      repeat (m_dur + 6) @(negedge clk);
   endtask

   task automatic wr(input bit rs, input logic [7:0] d, input bit acc);
      if (acc) mdl_write(rs, d);
      else q_pulse.push_back(1);
      bus_op(rs, 1'b0, d);
   endtask

   task automatic wrw(input bit rs, input logic [7:0] d);
      wr(rs, d, 1);
      idle();
   endtask

   task automatic rd(input bit rs, input bit bsy);
      q_rd.push_back(mdl_read(rs, bsy));
      bus_op(rs, 1'b1, 8'h00);
   endtask

   task automatic chk_mem(input int i, input string nm);
      mon_addr = 7'(i);
      #1;
      chk(nm, 32'(mon_data), 32'(m_mem[i]));
   endtask

   task automatic wait_busy(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 20);
      chk(nm, 32'(busy), 32'd1);
   endtask

   // Writes a command, then a data write whose E falls at negedge j after busy first appears.
   task automatic probe(input int jdrop, input logic [7:0] d, input bit acc);
      mdl_write(0, 8'h0E);
      if (acc) mdl_write(1, d);
      else q_pulse.push_back(1);
      @(negedge clk);
      bus.lcd_rs = 0;
      bus.lcd_rw = 0;
      bus.lcd_data_in = 8'h0E;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      bus.lcd_e = 1'b0;
      wait_busy("probe_rise");
      @(negedge clk);
      bus.lcd_rs = 1;
      bus.lcd_data_in = d;
      @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (jdrop - 2) @(negedge clk);
      bus.lcd_e = 1'b0;
      repeat (4) @(negedge clk);
      idle();
   endtask

   logic       oe_prev = 0;
   logic [7:0] rd_last = '0;
   always @(negedge clk) begin
      if (bus.lcd_data_oe) rd_last = bus.lcd_data_out;
      else if (oe_prev) begin
         if (q_rd.size() == 0) chk("read_unexpected", 32'(rd_last), 32'hFFFF);
         else chk("read_data", 32'(rd_last), 32'(q_rd.pop_front()));
      end
      oe_prev = bus.lcd_data_oe;
   end

   always @(negedge clk)
      if (rst_n) begin
         if (busy_violation) chk("busy_violation", 32'd1, q_pulse.size() ? 32'(q_pulse.pop_front()) : 32'd0);
         if (cmd_error) chk("cmd_error", 32'd2, q_pulse.size() ? 32'(q_pulse.pop_front()) : 32'd0);
      end

   int run = 0;
   always @(negedge clk)
      if (!rst_n) begin
         run = 0;
         q_busy.delete();
      end else if (busy) run++;
      else if (run > 0) begin
         chk("busy_len", 32'(run), q_busy.size() ? 32'(q_busy.pop_front()) : 32'd0);
         run = 0;
      end

   initial begin
      #900000;
      $display("FAIL timeout actual=running required=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      bus.lcd_e = 0;
      bus.lcd_rs = 0;
      bus.lcd_rw = 0;
      bus.lcd_data_in = 0;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ac", 32'(ac), 0);
      chk("rst_disp", 32'(disp_ctrl), 0);
      chk("rst_oe", 32'(bus.lcd_data_oe), 0);
      chk("rst_dout", 32'(bus.lcd_data_out), 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      wrw(0, 8'h01);
      for (int i = 0; i < 128; i++) chk_mem(i, "clear_fill");
      chk("clear_ac", 32'(ac), 0);
      wr(0, 8'h01, 1);
      rd(0, 1);
      idle();
      wr(0, 8'h38, 1);
      rd(0, 1);
      idle();
      wrw(0, 8'h0C);
      wrw(0, 8'h06);
      wrw(1, 8'h48);
      wrw(1, 8'h69);
      mon_addr = 7'h00;
      #1 chk("hello_m0", 32'(mon_data), 32'h48);
      mon_addr = 7'h01;
      #1 chk("hello_m1", 32'(mon_data), 32'h69);
      chk("hello_ac", 32'(ac), 32'h02);
      chk("hello_disp", 32'(disp_ctrl), 32'b100);
      wrw(0, 8'hA7);
      wrw(1, 8'h31);
      wrw(1, 8'h32);
      chk_mem(8'h27, "wrap_27");
      chk_mem(8'h40, "wrap_40");
      chk("wrap_ac", 32'(ac), 32'h41);
      wr(0, 8'h0C, 1);
      wr(1, 8'h55, 0);
      idle();
      chk_mem(int'(m_ac), "viol_mem");
      chk("viol_ac", 32'(ac), 32'(m_ac));
      probe(TCMD - 3, 8'h5A, 0);
      chk_mem(int'(m_ac), "edge_last_busy_mem");
      chk("edge_last_busy_ac", 32'(ac), 32'(m_ac));
      probe(TCMD - 2, 8'h5B, 1);
      chk_mem(int'(m_ac) - 1, "edge_idle_mem");
      chk("edge_idle_ac", 32'(ac), 32'(m_ac));
      wrw(0, 8'h04);
      wrw(0, 8'h80);
      wr(1, 8'h41, 1);
      rd(0, 1);
      idle();
      chk("dec_wrap_ac", 32'(ac), 32'h67);
      rd(0, 0);
      for (int k = 0; k < 80; k++) begin
         d = 8'($urandom);
         case ($urandom_range(0, 3))
            0: wrw(0, d);
            1: wrw(1, d);
            2: rd(0, 0);
            default: rd(1, 0);
         endcase
         chk("rand_ac", 32'(ac), 32'(m_ac));
         chk("rand_disp", 32'(disp_ctrl), 32'(m_disp));
      end
      wrw(0, 8'h06);
      wrw(0, 8'hB0);
      for (int i = 0; i < 6; i++) wrw(1, 8'hA0 + 8'(i));
      @(negedge clk);
      bus.lcd_rs = 0;
      bus.lcd_rw = 0;
      bus.lcd_data_in = 8'h01;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      bus.lcd_e = 1'b0;
      wait_busy("abort_rise");
      repeat (50) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ac", 32'(ac), 0);
      chk("abort_disp", 32'(disp_ctrl), 0);
      for (int i = 0; i < 50; i++) m_mem[i] = 8'h20;
      m_ac = 0;
      m_id = 1;
      m_n = 0;
      m_cg = 0;
      m_disp = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 128; i++) chk_mem(i, "abort_mem");
      repeat (10) @(negedge clk);
      chk("left_reads", 32'(q_rd.size()), 0);
      chk("left_pulses", 32'(q_pulse.size()), 0);
      chk("left_busy", 32'(q_busy.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
